// File: rtl/regbank_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : regbank_pkg
// Purpose  : Shared widths and write-FSM state encoding for the register bank,
//            its sequencer and the display.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package regbank_pkg;

  localparam int RB_ADDR_W = 3;   // 8 registers
  localparam int RB_DATA_W = 4;   // one hex digit per register

  typedef logic [2:0] wr_state_t;

  localparam wr_state_t ST_IDLE   = 3'd0;
  localparam wr_state_t ST_SETUP  = 3'd1;
  localparam wr_state_t ST_STROBE = 3'd2;
  localparam wr_state_t ST_HOLD   = 3'd3;
  localparam wr_state_t ST_VERIFY = 3'd4;

endpackage
`default_nettype wire

// File: rtl/regbank_seq_ctrl_scan_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : scan_tick_gen
// Purpose  : Free-running 0..SCAN_DIV-1 counter; tick is high in the cycle
//            where the count equals SCAN_DIV-1.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module scan_tick_gen #(
  parameter int SCAN_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int                CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: wrap to zero on the terminal value
  always_comb begin
    tick    = (count_q == C_CNT_LAST);
    count_d = tick ? '0 : count_q + CNT_W'(1);
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

endmodule
`default_nettype wire

// File: rtl/regbank_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : regbank_seq_ctrl
// Purpose  : Read-address sequencer (manual / auto-scan) and write handshake
//            for the 8x4 register bank feeding the 6-digit display.
// Options  : WR_VERIFY_EN - adds a read-back VERIFY state, rd_data_a input
//            and sticky wr_err output.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module regbank_seq_ctrl
  import regbank_pkg::*;
#(
  parameter int ADDR_W   = RB_ADDR_W,
  parameter int DATA_W   = RB_DATA_W,
  parameter int SCAN_DIV = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_scan,
  input  logic [ADDR_W-1:0] rd_a_in,
  input  logic [ADDR_W-1:0] rd_b_in,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr_in,
  input  logic [DATA_W-1:0] wr_data_in,
  output logic [ADDR_W-1:0] addRa,
  output logic [ADDR_W-1:0] addRb,
  output logic [ADDR_W-1:0] addrW,
  output logic [DATA_W-1:0] datW,
  output logic              we,
  output logic              busy,
  output logic              wr_done,
`ifdef WR_VERIFY_EN
  input  logic [DATA_W-1:0] rd_data_a,
  output logic              wr_err,
`endif
  output logic              led
);

  wr_state_t         state_q, state_d;
  logic              wr_q;
  logic              start;
  logic              tick;
  logic [ADDR_W-1:0] addRa_q, addRa_d;
  logic [ADDR_W-1:0] addRb_q, addRb_d;
  logic [ADDR_W-1:0] addrW_q, addrW_d;
  logic [DATA_W-1:0] datW_q,  datW_d;
  logic              led_q,   led_d;

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign start = wr_req & ~wr_q;

  // Write FSM next state; write address/data latch only on an accepted start
  always_comb begin
    state_d = state_q;
    addrW_d = addrW_q;
    datW_d  = datW_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          addrW_d = wr_addr_in;
          datW_d  = wr_data_in;
        end
      end
      ST_SETUP:  state_d = ST_STROBE;
      ST_STROBE: state_d = ST_HOLD;
`ifdef WR_VERIFY_EN
      ST_HOLD:   state_d = ST_VERIFY;
      ST_VERIFY: state_d = ST_IDLE;
`else
      ST_HOLD:   state_d = ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  // Read addresses: follow manual inputs, or step on a tick while idle
  always_comb begin
    addRa_d = addRa_q;
    addRb_d = addRb_q;
    led_d   = led_q;
    if (!mode_scan) begin
      addRa_d = rd_a_in;
      addRb_d = rd_b_in;
    end else if (tick && (state_q == ST_IDLE)) begin
      addRa_d = addRa_q + ADDR_W'(1);
      addRb_d = addRa_q + ADDR_W'(2);   // keeps addRb one ahead of the new addRa
      led_d   = ~led_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      addRa_q <= '0;
      addRb_q <= ADDR_W'(1);
      addrW_q <= '0;
      datW_q  <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_req;
      addRa_q <= addRa_d;
      addRb_q <= addRb_d;
      addrW_q <= addrW_d;
      datW_q  <= datW_d;
      led_q   <= led_d;
    end
  end

`ifdef WR_VERIFY_EN
  logic wr_err_q, wr_err_d;

  // Sticky read-back error, judged at the end of the VERIFY cycle
  always_comb begin
    wr_err_d = wr_err_q;
    if ((state_q == ST_VERIFY) && (rd_data_a != datW_q)) wr_err_d = 1'b1;
  end

  // Error flag register
  always_ff @(posedge clk) begin
    if (rst) wr_err_q <= 1'b0;
    else     wr_err_q <= wr_err_d;
  end

  assign wr_err = wr_err_q;
  // addRa_q is untouched during VERIFY, so the pre-write address returns afterwards
  assign addRa  = (state_q == ST_VERIFY) ? addrW_q : addRa_q;
`else
  assign addRa  = addRa_q;
`endif

  assign addRb   = addRb_q;
  assign addrW   = addrW_q;
  assign datW    = datW_q;
  assign led     = led_q;
  assign we      = (state_q == ST_STROBE);
  assign wr_done = (state_q == ST_HOLD);
  assign busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_regbank_seq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_regbank_seq_ctrl
// Purpose  : Self-checking bench for regbank_seq_ctrl with SCAN_DIV=4.
// Options  : WR_VERIFY_EN - also exercises the read-back verify path.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_regbank_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode_scan;
  logic [2:0] rd_a_in, rd_b_in, wr_addr_in;
  logic       wr_req;
  logic [3:0] wr_data_in;
  logic [2:0] addRa, addRb, addrW;
  logic [3:0] datW;
  logic       we, busy, wr_done, led;

  int n_checks = 0;
  int n_errors = 0;

`ifdef WR_VERIFY_EN
  logic [3:0] rd_data_a;
  logic       wr_err;
  logic [3:0] bank [8];
  logic       corrupt = 1'b0;

  always @(posedge clk) if (we) bank[addrW] <= datW;
  assign rd_data_a = bank[addRa] ^ {3'b000, corrupt};
`endif

  regbank_seq_ctrl #(
    .ADDR_W   (3),
    .DATA_W   (4),
    .SCAN_DIV (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mode_scan  (mode_scan),
    .rd_a_in    (rd_a_in),
    .rd_b_in    (rd_b_in),
    .wr_req     (wr_req),
    .wr_addr_in (wr_addr_in),
    .wr_data_in (wr_data_in),
    .addRa      (addRa),
    .addRb      (addRb),
    .addrW      (addrW),
    .datW       (datW),
    .we         (we),
    .busy       (busy),
    .wr_done    (wr_done),
`ifdef WR_VERIFY_EN
    .rd_data_a  (rd_data_a),
    .wr_err     (wr_err),
`endif
    .led        (led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       mode;
    logic [2:0] ra;
    logic [2:0] rb;
    logic       wr;
    logic [2:0] wa;
    logic [3:0] wd;
    logic [2:0] e_ra;
    logic [2:0] e_rb;
    logic [2:0] e_aw;
    logic [3:0] e_dw;
    logic       e_we;
    logic       e_busy;
    logic       e_done;
    logic       e_led;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int we_cnt, done_cnt, toggles, s;
    logic led_prev;

    //          rst  mode ra  rb  wr  wa  wd     e_ra e_rb e_aw e_dw we busy done led
    tbl[0]  = '{1'b1,1'b0,3'd0,3'd1,1'b0,3'd0,4'h0, 3'd0,3'd1,3'd0,4'h0,1'b0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b1,1'b0,3'd0,3'd1,1'b0,3'd0,4'h0, 3'd0,3'd1,3'd0,4'h0,1'b0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b1,1'b0,3'd0,3'd1,1'b0,3'd0,4'h0, 3'd0,3'd1,3'd0,4'h0,1'b0,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,3'd0,3'd1,1'b1,3'd7,4'h7, 3'd0,3'd1,3'd7,4'h7,1'b0,1'b1,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,3'd0,3'd1,1'b1,3'd7,4'h7, 3'd0,3'd1,3'd7,4'h7,1'b1,1'b1,1'b0,1'b0};
    tbl[5]  = '{1'b0,1'b0,3'd0,3'd1,1'b1,3'd7,4'h7, 3'd0,3'd1,3'd7,4'h7,1'b0,1'b1,1'b1,1'b0};
    tbl[6]  = '{1'b0,1'b0,3'd0,3'd1,1'b1,3'd7,4'h7, 3'd0,3'd1,3'd7,4'h7,1'b0,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b0,3'd1,3'd2,1'b0,3'd3,4'h2, 3'd1,3'd2,3'd7,4'h7,1'b0,1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b0,3'd1,3'd2,1'b0,3'd3,4'h2, 3'd1,3'd2,3'd7,4'h7,1'b0,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b0,3'd6,3'd3,1'b0,3'd3,4'h2, 3'd6,3'd3,3'd7,4'h7,1'b0,1'b0,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b0,3'd6,3'd3,1'b1,3'd2,4'h9, 3'd6,3'd3,3'd2,4'h9,1'b0,1'b1,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b0,3'd6,3'd3,1'b1,3'd0,4'h1, 3'd6,3'd3,3'd2,4'h9,1'b1,1'b1,1'b0,1'b0};
    tbl[12] = '{1'b0,1'b0,3'd6,3'd3,1'b1,3'd0,4'h1, 3'd6,3'd3,3'd2,4'h9,1'b0,1'b1,1'b1,1'b0};
    tbl[13] = '{1'b0,1'b0,3'd6,3'd3,1'b0,3'd0,4'h1, 3'd6,3'd3,3'd2,4'h9,1'b0,1'b0,1'b0,1'b0};

`ifdef WR_VERIFY_EN
    for (int i = 0; i < 8; i++) bank[i] = 4'h0;
`endif

    // Reset, write handshake, manual addressing
    for (int i = 0; i < NVEC; i++) begin
      rst        = tbl[i].rst;
      mode_scan  = tbl[i].mode;
      rd_a_in    = tbl[i].ra;
      rd_b_in    = tbl[i].rb;
      wr_req     = tbl[i].wr;
      wr_addr_in = tbl[i].wa;
      wr_data_in = tbl[i].wd;
      step();
      check($sformatf("vec%0d", i),
            {15'd0, addRa, addRb, addrW, datW, we, busy, wr_done, led},
            {15'd0, tbl[i].e_ra, tbl[i].e_rb, tbl[i].e_aw, tbl[i].e_dw,
             tbl[i].e_we, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_led});
    end

    // Auto-scan over 40 idle clocks from reset
    rst = 1'b1; mode_scan = 1'b1; wr_req = 1'b0;
    step();
    rst = 1'b0;
    toggles = 0;
    led_prev = led;
    for (int j = 0; j < 40; j++) begin
      step();
      s = (j + 1) / 4;
      check($sformatf("scan%0d", j), {26'd0, addRa, addRb},
            {26'd0, 3'(s % 8), 3'((s + 1) % 8)});
      if (led != led_prev) toggles++;
      led_prev = led;
    end
    check("scan_toggles", toggles, 10);
    check("scan_final_ra", {29'd0, addRa}, 32'd2);

    // Tick during STROBE and a second request while busy
    rst = 1'b1; mode_scan = 1'b1; wr_req = 1'b0;
    step();
    rst = 1'b0;
    we_cnt = 0; done_cnt = 0;
    for (int j = 0; j < 11; j++) begin
      wr_req     = (j == 1) || (j >= 3);
      wr_addr_in = (j == 1) ? 3'd5 : 3'd2;
      wr_data_in = (j == 1) ? 4'hA : 4'h3;
      if (j == 3) check("coll_strobe", {30'd0, we, busy}, 32'd3);
      if (j == 4) check("coll_tick_dropped", {28'd0, addRa, led}, 32'd0);
      if (j == 8) check("coll_next_tick", {28'd0, addRa, led}, {28'd0, 3'd1, 1'b1});
      we_cnt   += int'(we);
      done_cnt += int'(wr_done);
      step();
    end
    check("coll_we_count", we_cnt, 1);
    check("coll_done_count", done_cnt, 1);
    check("coll_latched", {25'd0, addrW, datW}, {25'd0, 3'd5, 4'hA});

    // Manual mode: one-clock latency, led frozen across ticks
    wr_req = 1'b0; mode_scan = 1'b0; rd_a_in = 3'd4; rd_b_in = 3'd0;
    check("man_before", {29'd0, addRa}, 32'd1);
    step();
    check("man_latency", {26'd0, addRa, addRb}, {26'd0, 3'd4, 3'd0});
    for (int j = 0; j < 8; j++) step();
    check("man_led_frozen", {31'd0, led}, 32'd1);

    // Back to scan: continue from addRa, addRb realigned on first tick
    mode_scan = 1'b1;
    for (int j = 0; j < 8 && addRa == 3'd4; j++) step();
    check("rescan", {25'd0, addRa, addRb, led}, {25'd0, 3'd5, 3'd6, 1'b0});

    // Reset asserted during SETUP aborts the write
    mode_scan = 1'b0; rd_a_in = 3'd0; rd_b_in = 3'd1; wr_req = 1'b0;
    step();
    wr_req = 1'b1; wr_addr_in = 3'd4; wr_data_in = 4'h6;
    step();
    check("rsetup_busy", {31'd0, busy}, 32'd1);
    wr_req = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("rsetup_abort", {24'd0, busy, we, wr_done, addrW, datW}, 32'd0);
    we_cnt = 0; done_cnt = 0;
    for (int j = 0; j < 6; j++) begin
      we_cnt   += int'(we) + int'(busy);
      done_cnt += int'(wr_done);
      step();
    end
    check("rsetup_no_we", we_cnt, 0);
    check("rsetup_no_done", done_cnt, 0);

`ifdef WR_VERIFY_EN
    // Read-back matches: no error, busy extends through VERIFY
    rd_a_in = 3'd1;
    wr_req = 1'b1; wr_addr_in = 3'd3; wr_data_in = 4'h5;
    step();
    wr_req = 1'b0;
    step(); step(); step();
    check("ver_busy", {28'd0, addRa, busy}, {28'd0, 3'd3, 1'b1});
    step();
    check("ver_ok", {27'd0, addRa, busy, wr_err}, {27'd0, 3'd1, 1'b0, 1'b0});

    // Corrupted read-back: wr_err at N+5, sticky until reset
    corrupt = 1'b1;
    wr_req = 1'b1; wr_addr_in = 3'd6; wr_data_in = 4'hC;
    step();
    wr_req = 1'b0;
    step(); step(); step();
    check("ver_err_n4", {31'd0, wr_err}, 32'd0);
    step();
    check("ver_err_n5", {31'd0, wr_err}, 32'd1);
    step(); step(); step();
    check("ver_err_sticky", {31'd0, wr_err}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("ver_err_rst", {31'd0, wr_err}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
